// File: rtl/am2940_param.sv
// Parameterised Am2940-style DMA address generator: control register, address/word counters, done logic.
// Optional build macro AM2940_AUTOREINIT_EN: reload AC/WC from AR/WCR when an enable cycle hits done.
module am2940_param #(
  parameter int WIDTH = 8,
  parameter int CR_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       instr,
  input  logic [WIDTH-1:0] datain,
  output logic [WIDTH-1:0] dataout,
  output logic             oedata,
  input  logic             cina,
  input  logic             cinw,
  output logic             cona,
  output logic             conw,
  output logic             done
);

  typedef enum logic [2:0] {
    I_WRCR   = 3'b000,
    I_RDCR   = 3'b001,
    I_RDWC   = 3'b010,
    I_RDAC   = 3'b011,
    I_REINIT = 3'b100,
    I_LDAR   = 3'b101,
    I_LDWC   = 3'b110,
    I_EN     = 3'b111
  } instr_e;

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [CR_W-1:0]  cr_q, cr_d;
  logic [WIDTH-1:0] ar_q, ar_d, ac_q, ac_d, wcr_q, wcr_d, wc_q, wc_d;
  instr_e           op;
  logic [1:0]       mode;
  logic             ac_dn, stop, ac_term, wc_term, auto_rl;

  assign op    = instr_e'(instr);
  assign mode  = cr_q[1:0];
  assign ac_dn = cr_q[2];
  assign stop  = cr_q[3];

  // Terminal value is where the next count would wrap.
  assign ac_term = ac_dn ? (ac_q == '0) : (ac_q == ONES);
  assign wc_term = (mode == 2'b00) ? (wc_q == '0) : (wc_q == ONES);
  assign cona    = ~(~cina & ac_term);
  assign conw    = (mode == 2'b10) ? cinw : ~(~cinw & wc_term);

  always_comb begin
    done = 1'b0;
    case (mode)
      2'b00: done = (wc_q == ONE);
      2'b01: done = (wc_q == wcr_q);
      2'b10: done = (ac_q == wcr_q);
      2'b11: done = (wc_q == ONES) & ~cinw;
      default: done = 1'b0;
    endcase
  end

`ifdef AM2940_AUTOREINIT_EN
  assign auto_rl = done & ~stop;
`else
  assign auto_rl = 1'b0;
`endif

  always_comb begin
    cr_d  = cr_q;
    ar_d  = ar_q;
    ac_d  = ac_q;
    wcr_d = wcr_q;
    wc_d  = wc_q;
    case (op)
      I_WRCR: cr_d = CR_W'(datain);
      I_REINIT: begin
        ac_d = ar_q;
        wc_d = (mode == 2'b01) ? '0 : wcr_q;
      end
      I_LDAR: begin
        ar_d = datain;
        ac_d = datain;
      end
      I_LDWC: begin
        wcr_d = datain;
        wc_d  = (mode == 2'b01) ? '0 : datain;
      end
      I_EN: begin
        if (stop && done) begin
          ac_d = ac_q;
        end else if (auto_rl) begin
          ac_d = ar_q;
          wc_d = (mode == 2'b01) ? '0 : wcr_q;
        end else begin
          if (!cina) ac_d = ac_dn ? ac_q - ONE : ac_q + ONE;
          if (!cinw) begin
            case (mode)
              2'b00:        wc_d = wc_q - ONE;
              2'b01, 2'b11: wc_d = wc_q + ONE;
              default:      wc_d = wc_q;
            endcase
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr_q  <= '0;
      ar_q  <= '0;
      ac_q  <= '0;
      wcr_q <= '0;
      wc_q  <= '0;
    end else begin
      cr_q  <= cr_d;
      ar_q  <= ar_d;
      ac_q  <= ac_d;
      wcr_q <= wcr_d;
      wc_q  <= wc_d;
    end
  end

  // Read port is forced quiet while reset is held.
  always_comb begin
    dataout = '0;
    oedata  = 1'b0;
    if (rst_n) begin
      case (op)
        I_RDCR: begin dataout = WIDTH'(cr_q); oedata = 1'b1; end
        I_RDWC: begin dataout = wc_q;         oedata = 1'b1; end
        I_RDAC: begin dataout = ac_q;         oedata = 1'b1; end
        default: ;
      endcase
    end
  end

endmodule
